// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-enabled data memory: funct3 codes, FSM states
// and the funct3 legality rule used by the request decoder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_memory_be_if.sv
// Load/store request port with a registered, non-backpressured response.
interface data_memory_be_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store enables/replicated data and load
// lane extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  // Data is replicated across lanes so the enables alone pick the target bytes.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    be    = '0;
    wword = '0;
    case (funct3)
      F3_B: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
      end
      F3_H: begin
        be    = 4'b0011 << lane;
        wword = {2{wdata[15:0]}};
      end
      F3_W: begin
        be    = 4'b1111;
        wword = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = rword >> {lane, 3'b000};
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    rdata = rword;
      F3_BU:   rdata = {24'h0, shifted[7:0]};
      F3_HU:   rdata = {16'h0, shifted[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_be.sv
// Word-organised RV32 data memory with byte enables, 1-cycle registered
// response, access-fault reporting and an optional post-reset clear sequence.
module data_memory_be
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  data_memory_be_if.slave  bus,
  output logic             init_done
);

  localparam int             AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_t        state, state_next;
  logic [AW-1:0] clr_idx;
  logic          run_q;
  logic          clr_we;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic          f3_ok, misaligned, out_of_range, req_err;
  logic          accept, do_store;
  logic [3:0]    be;
  logic [31:0]   wword, load_data;

  // State register; run_q mirrors "in RUN" but is 0 while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if (CLEAR_ON_RESET) state <= ST_INIT;
      else                state <= ST_RUN;
      clr_idx <= '0;
      run_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      run_q <= (state_next == ST_RUN);
      if (state == ST_INIT) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (clr_idx == LAST_IDX) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  always_comb begin
    clr_we        = (state == ST_INIT);
    bus.req_ready = run_q;
    init_done     = run_q;
  end

  // Address decode relative to the window base.
  always_comb begin
    off          = bus.req_addr - BASE_ADDR;
    lane         = off[1:0];
    word_idx     = off[AW+1:2];
    f3_ok        = funct3_legal(bus.req_we, bus.req_funct3);
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && lane[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (lane != 2'b00));
    out_of_range = (bus.req_addr < BASE_ADDR) ||
                   ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));
    req_err      = !f3_ok || misaligned || out_of_range;
    accept       = bus.req_valid && bus.req_ready;
    do_store     = accept && bus.req_we && !req_err;
  end

  dmem_lane_align u_align (
    .funct3 (bus.req_funct3),
    .lane   (lane),
    .wdata  (bus.req_wdata),
    .rword  (mem[word_idx]),
    .be     (be),
    .wword  (wword),
    .rdata  (load_data)
  );

  // NOTE: the array has no reset; clearing is done by the INIT sequence so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // Response data/err hold their last value between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= accept;
      if (accept) begin
        bus.rsp_err   <= req_err;
        bus.rsp_rdata <= (!bus.req_we && !req_err) ? load_data : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_be.sv
// Self-checking bench for data_memory_be: directed load/store cases plus
// random traffic scored against a byte-array reference model.
module tb_data_memory_be;
  import dmem_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic init_done;

  data_memory_be_if bus();

  data_memory_be #(
    .DEPTH_WORDS    (DEPTH),
    .BASE_ADDR      (BASE),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  byte unsigned ref_mem [DEPTH*4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array addressed by (addr - BASE).
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [2:0] f3, output logic err, output logic [31:0] rd);
    int     size;
    longint off;
    logic   legal;
    logic [31:0] v;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = longint'(addr) - longint'(BASE);
    err   = !legal || (off % size != 0) || (off < 0) || (off >= DEPTH*4);
    rd    = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_mem[int'(off) + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_mem[int'(off) + i]) << (8*i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 1);
        rd = v;
      end
    end
  endfunction

  // One cycle of stimulus starting at a falling edge; checks the response after the rising edge.
  task automatic step(input logic v, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [2:0] f3, input string tag);
    logic acc, err;
    logic [31:0] rd;
    bus.req_valid  = v;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_funct3 = f3;
    acc = v && bus.req_ready;
    err = 1'b0;
    rd  = 32'h0;
    if (acc) model(we, addr, wd, f3, err, rd);
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 32'(bus.rsp_valid), 32'(acc));
    if (acc) begin
      check({tag, ".err"},   32'(bus.rsp_err), 32'(err));
      check({tag, ".rdata"}, bus.rsp_rdata, rd);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Waits out the clear sequence while offering a store that must be ignored.
  task automatic wait_init(input string tag);
    int cnt = 0;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = BASE;
    bus.req_wdata  = 32'hFFFF_FFFF;
    bus.req_funct3 = F3_W;
    while (!bus.req_ready && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
      check({tag, ".no_rsp"}, 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 1'b0;
    check({tag, ".cycles"}, 32'(cnt), 32'(DEPTH));
    check({tag, ".init_done"}, 32'(init_done), 32'd1);
    @(negedge clk);
  endtask

  logic        r_v, r_we;
  logic [31:0] r_addr, r_wd;
  logic [2:0]  r_f3;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;

    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.ready",     32'(bus.req_ready), 32'd0);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_err",   32'(bus.rsp_err),   32'd0);
    check("rst.rsp_rdata", bus.rsp_rdata,      32'd0);
    check("rst.init_done", 32'(init_done),     32'd0);
    reset = 1'b1;
    wait_init("init0");

    step(1, 0, BASE + 32'h3C, 0, F3_W, "lw_clear");
    step(1, 0, BASE + 32'h00, 0, F3_W, "lw_ignored_init_store");

    // Back-to-back SW/SB/SH then LW.
    step(1, 1, BASE + 32'h8, 32'h1122_3344, F3_W, "sw8");
    step(1, 1, BASE + 32'h9, 32'h0000_00AB, F3_B, "sb9");
    step(1, 1, BASE + 32'hA, 32'h0000_BEEF, F3_H, "sha");
    step(1, 0, BASE + 32'h8, 0, F3_W, "lw8");
    check("lw8.exact", bus.rsp_rdata, 32'hBEEF_AB44);
    step(0, 0, 0, 0, F3_W, "idle");

    // Extension.
    step(1, 1, BASE + 32'h4, 32'h80FF_7F80, F3_W, "sw4");
    step(1, 0, BASE + 32'h4, 0, F3_B,  "lb4");
    check("lb4.exact", bus.rsp_rdata, 32'hFFFF_FF80);
    step(1, 0, BASE + 32'h4, 0, F3_BU, "lbu4");
    check("lbu4.exact", bus.rsp_rdata, 32'h0000_0080);
    step(1, 0, BASE + 32'h6, 0, F3_H,  "lh6");
    check("lh6.exact", bus.rsp_rdata, 32'hFFFF_80FF);
    step(1, 0, BASE + 32'h6, 0, F3_HU, "lhu6");
    check("lhu6.exact", bus.rsp_rdata, 32'h0000_80FF);

    // Errors.
    step(1, 0, BASE + 32'h2, 0, F3_W, "err_lw_mis");
    step(1, 1, BASE + 32'h5, 32'h1234, F3_H, "err_sh_mis");
    step(1, 0, BASE + 32'h4, 0, F3_W, "lw4_unchanged");
    check("lw4_unchanged.exact", bus.rsp_rdata, 32'h80FF_7F80);
    step(1, 0, BASE + 4*DEPTH, 0, F3_W, "err_lw_oor");
    step(1, 0, BASE - 4, 0, F3_W, "err_lw_below");
    step(1, 1, BASE + 32'hC, 32'h5555_5555, 3'b100, "err_st_f3");
    step(1, 0, BASE + 32'hC, 0, 3'b011, "err_ld_f3");

    // Write-then-read hazard.
    step(1, 1, BASE + 32'h10, 32'hDEAD_BEEF, F3_W, "sw10");
    step(1, 0, BASE + 32'h10, 0, F3_W, "lw10");
    check("lw10.exact", bus.rsp_rdata, 32'hDEAD_BEEF);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      r_v    = ($urandom_range(0, 3) != 0);
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_wd   = $urandom;
      r_addr = BASE - 8 + 32'($urandom_range(0, DEPTH*4 + 16));
      if ($urandom_range(0, 3) != 0) begin
        if (r_f3[1:0] == 2'd1) r_addr[0] = 1'b0;
        else if (r_f3[1:0] == 2'd2) r_addr[1:0] = 2'b00;
      end
      step(r_v, r_we, r_addr, r_wd, r_f3, "rand");
    end

    // Reset in the middle of the clear sequence.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_init.ready", 32'(bus.req_ready), 32'd0);
    check("rst_init.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_init("init1");

    // Reset with a response pending.
    step(1, 1, BASE + 32'h20, 32'hCAFE_F00D, F3_W, "sw20");
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = BASE + 32'h20;
    bus.req_funct3 = F3_W;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("pend.rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("pend.rdata", bus.rsp_rdata, 32'hCAFE_F00D);
    reset = 1'b0;
    #1;
    check("pend_rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("pend_rst.init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_init("init2");
    step(1, 0, BASE + 32'h20, 0, F3_W, "lw20_cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
